mul_result_stage: RTL and testbench
===================================

// Module: mul_result_stage
// PURPOSE
//  Downstream of the combinational 64x64 signed multiplier in the RV64IM execute path.
//  Consumes the 128-bit signed product plus the original operands and the MULControl code.
//  Produces the architectural MUL/MULH/MULHSU/MULHU/MULW result.
//  Buffers results in a DEPTH-entry FIFO with valid/ready toward writeback, and backpressures issue.
// PARAMETERS
//  XLEN   64  operand/result width
//  DEPTH  2   result FIFO entries (power of 2, >=2)
//  TAGW   5   destination-register tag width
// PORTS
//  clk          in   1        clock, rising edge
//  rst          in   1        asynchronous reset, active-high
//  flush        in   1        pipeline flush; drops all buffered and incoming results
//  in_valid     in   1        product/operands valid this cycle
//  in_ready     out  1        stage can accept (registered)
//  in_ctrl      in   3        MULControl code (mul_op_e)
//  in_rs1       in   XLEN     operand 1 as presented to multiplier
//  in_rs2       in   XLEN     operand 2 as presented to multiplier
//  in_product   in   2*XLEN   signed rs1*rs2 from multiplier
//  in_rd        in   TAGW     destination tag
//  out_valid    out  1        result at FIFO head valid
//  out_ready    in   1        writeback accepts head
//  out_result   out  XLEN     formatted result
//  out_rd       out  TAGW     destination tag of head
// BEHAVIOUR
//  Reset: count=0, rd/wr ptr=0, in_ready=1, out_valid=0, out_result=0, out_rd=0.
//  Push when in_valid&in_ready&!flush; pop when out_valid&out_ready&!flush.
//  Latency: pushed at edge N -> visible on out_* after edge N (1 cycle); FIFO is not fall-through.
//  in_ready registered = (count_next < DEPTH); a full FIFO does not accept in the cycle it pops.
//  Simultaneous push+pop (count 1..DEPTH-1): count unchanged, both pointers advance, mod DEPTH.
//  Pointers wrap at DEPTH; count saturates 0..DEPTH; no push when full, no pop when empty.
//  out_result/out_rd hold head entry; they hold the last popped value when empty (out_valid=0).
//  flush: next edge count=0, ptrs=0, out_valid=0, in_ready=1; same-cycle push/pop discarded.
//  Async rst mid-operation: immediate return to reset state; no partial entry survives.
//  Result formatting (combinational before FIFO write), hi=product[127:64], lo=product[63:0]:
//   MUL    3'b100: lo
//   MULH   3'b101: hi
//   MULHSU 3'b110: hi + (rs2[63] ? rs1 : 0)                      (rs2 unsigned fix-up)
//   MULHU  3'b111: hi + (rs2[63] ? rs1 : 0) + (rs1[63] ? rs2 : 0) (both unsigned fix-up)
//   MULW   3'b000: {{32{lo[31]}}, lo[31:0]}
//   other codes: result 0, entry still pushed (decoder guarantees legal codes; bench flags).
//  Fix-up sums are mod 2^XLEN; carries discarded.
//  No state machine beyond FIFO occupancy.
//  Occupancy states: EMPTY(count=0) / PARTIAL / FULL(count=DEPTH).
//   EMPTY --push--> PARTIAL (FULL if DEPTH=1); PARTIAL --push&!pop--> FULL/PARTIAL;
//   PARTIAL --pop&!push--> EMPTY/PARTIAL; FULL --pop--> PARTIAL; any --flush--> EMPTY.
// STRUCTURE
//  Package mext_pkg: typedef enum logic[2:0] mul_op_e {MUL_W=3'b000, MUL_LO=3'b100,
//   MUL_H=3'b101, MUL_HSU=3'b110, MUL_HU=3'b111}; XLEN localparam; mul_entry_t {result, rd}.
//  Sub-module mul_fmt: purely combinational product->result formatter; FIFO and handshake at top.
// TESTING
//  MUL rs1=3 rs2=-2 product=-6 -> out_result=64'hFFFF_FFFF_FFFF_FFFA one cycle after push.
//  MULHU rs1=64'hFFFF_FFFF_FFFF_FFFF rs2=2 product=-2 -> out_result=64'h1.
//  MULHSU rs1=-1 rs2=2 product=-2 -> out_result=64'hFFFF_FFFF_FFFF_FFFF.
//  MULW rs1=32'h7FFF_FFFF rs2=2 -> out_result=64'hFFFF_FFFF_FFFF_FFFE.
//  Backpressure: out_ready=0, 3 back-to-back pushes -> in_ready=0 after 2nd;
//   3rd held; release gives in-order rd tags.
//  flush with 2 entries + concurrent push -> next cycle out_valid=0, in_ready=1;
//   async rst mid-burst -> reset values immediately.

Source files
------------

// File: rtl/mext_pkg.sv
// Shared types and widths for the M-extension multiply result path.
package mext_pkg;

  localparam int XLEN = 64;
  localparam int TAGW = 5;

  // MULControl encoding as produced by the decoder.
  typedef enum logic [2:0] {
    MUL_W   = 3'b000,
    MUL_LO  = 3'b100,
    MUL_H   = 3'b101,
    MUL_HSU = 3'b110,
    MUL_HU  = 3'b111
  } mul_op_e;

  // One buffered writeback entry.
  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [TAGW-1:0] rd;
  } mul_entry_t;

endpackage

// File: rtl/mul_fmt.sv
// Combinational formatter: turns the signed 128-bit product into the
// architectural result for the selected multiply flavour.
module mul_fmt
  import mext_pkg::*;
(
  input  logic [2:0]        ctrl,
  input  logic [XLEN-1:0]   rs1,
  input  logic [XLEN-1:0]   rs2,
  input  logic [2*XLEN-1:0] product,
  output logic [XLEN-1:0]   result
);

  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN-1:0] fix_rs1;
  logic [XLEN-1:0] fix_rs2;

  assign hi = product[2*XLEN-1:XLEN];
  assign lo = product[XLEN-1:0];

  // The multiplier treats both operands as signed. An operand that is
  // really unsigned with its top bit set was seen as (x - 2^XLEN), so the
  // upper half is short by the other operand; these terms add it back.
  assign fix_rs1 = rs2[XLEN-1] ? rs1 : '0;
  assign fix_rs2 = rs1[XLEN-1] ? rs2 : '0;

  // Select the result slice / fix-up for the operation; illegal codes give 0.
  always_comb begin
    result = '0;
    case (ctrl)
      MUL_LO:  result = lo;
      MUL_H:   result = hi;
      MUL_HSU: result = hi + fix_rs1;
      MUL_HU:  result = hi + fix_rs1 + fix_rs2;
      MUL_W:   result = {{(XLEN-32){lo[31]}}, lo[31:0]};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/mul_result_stage.sv
// Multiply result stage: formats the product and buffers results in a
// small registered-output FIFO toward writeback, with registered in_ready.
module mul_result_stage
  import mext_pkg::*;
#(
  parameter int XLEN  = mext_pkg::XLEN,
  parameter int DEPTH = 2,
  parameter int TAGW  = mext_pkg::TAGW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          in_ctrl,
  input  logic [XLEN-1:0]     in_rs1,
  input  logic [XLEN-1:0]     in_rs2,
  input  logic [2*XLEN-1:0]   in_product,
  input  logic [TAGW-1:0]     in_rd,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_result,
  output logic [TAGW-1:0]     out_rd
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0] rd_ptr, rd_ptr_next;
  logic [PW-1:0] wr_ptr, wr_ptr_next;
  logic [CW-1:0] count, count_next;
  logic          in_ready_q;
  logic          push, pop;

  logic [XLEN-1:0] fmt_result;
  mul_entry_t      new_entry;
  mul_entry_t      head_q, head_next;
  mul_entry_t      mem [DEPTH];

  mul_fmt u_fmt (
    .ctrl    (in_ctrl),
    .rs1     (in_rs1),
    .rs2     (in_rs2),
    .product (in_product),
    .result  (fmt_result)
  );

  assign new_entry.result = fmt_result;
  assign new_entry.rd     = in_rd;

  assign push = in_valid && in_ready_q && !flush;
  assign pop  = (count != '0) && out_ready && !flush;

  // Next occupancy, pointers and head entry. The head is kept in its own
  // register so the outputs hold the last popped entry once the FIFO drains.
  always_comb begin
    rd_ptr_next = rd_ptr;
    wr_ptr_next = wr_ptr;
    count_next  = count;
    head_next   = head_q;
    if (flush) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) wr_ptr_next = wr_ptr + PW'(1);
      if (pop)  rd_ptr_next = rd_ptr + PW'(1);
      if (push && !pop)      count_next = count + CW'(1);
      else if (pop && !push) count_next = count - CW'(1);
      if (count_next != '0) begin
        // The new head is the entry being written this cycle when it lands
        // exactly at the next read position; otherwise it is already stored.
        if (push && (rd_ptr_next == wr_ptr)) head_next = new_entry;
        else                                 head_next = mem[rd_ptr_next];
      end
    end
  end

  // Occupancy, pointers, registered ready and head register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      in_ready_q <= 1'b1;
      head_q     <= '0;
    end else begin
      rd_ptr     <= rd_ptr_next;
      wr_ptr     <= wr_ptr_next;
      count      <= count_next;
      in_ready_q <= (count_next < CW'(DEPTH));
      head_q     <= head_next;
    end
  end

  // Entry storage; cleared on reset so nothing from before reset can reappear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= new_entry;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = (count != '0);
  assign out_result = head_q.result;
  assign out_rd     = head_q.rd;

endmodule

// File: tb/tb_mul_result_stage.sv
// Directed self-checking bench for mul_result_stage.
module tb_mul_result_stage;
  import mext_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_ctrl;
  logic [63:0]  in_rs1, in_rs2;
  logic [127:0] in_product;
  logic [4:0]   in_rd;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_result;
  logic [4:0]   out_rd;

  int n_chk  = 0;
  int n_fail = 0;

  mul_result_stage #(.XLEN(64), .DEPTH(2), .TAGW(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ctrl    (in_ctrl),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_product (in_product),
    .in_rd      (in_rd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd     (out_rd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  ctrl;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [4:0]  rd;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] smul(input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] sa;
    logic signed [127:0] sb;
    sa = {{64{a[63]}}, a};
    sb = {{64{b[63]}}, b};
    return sa * sb;
  endfunction

  task automatic drive(input logic [2:0] c, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] r);
    in_ctrl    = c;
    in_rs1     = a;
    in_rs2     = b;
    in_product = smul(a, b);
    in_rd      = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] tags[3];
    int got;
    logic acc;

    vecs[0]  = '{3'b100, 64'd3, -64'sd2, 5'd1, 64'hFFFF_FFFF_FFFF_FFFA};
    vecs[1]  = '{3'b111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd2, 64'h1};
    vecs[2]  = '{3'b110, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[3]  = '{3'b000, 64'h7FFF_FFFF, 64'd2, 5'd4, 64'hFFFF_FFFF_FFFF_FFFE};
    vecs[4]  = '{3'b101, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd5, 64'h0};
    vecs[5]  = '{3'b111, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd6,
                 64'h4000_0000_0000_0000};
    vecs[6]  = '{3'b110, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 5'd7,
                 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[7]  = '{3'b101, 64'h4000_0000_0000_0000, 64'd4, 5'd8, 64'h1};
    vecs[8]  = '{3'b000, 64'd5, 64'd7, 5'd9, 64'h23};
    vecs[9]  = '{3'b100, 64'h1_0000_0000, 64'h1_0000_0000, 5'd10, 64'h0};
    vecs[10] = '{3'b001, 64'd9, 64'd9, 5'd11, 64'h0};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(3'b100, 64'd0, 64'd0, 5'd0);
    #12;
    chk("rst_in_ready",   64'(in_ready),   64'd1);
    chk("rst_out_valid",  64'(out_valid),  64'd0);
    chk("rst_out_result", out_result,      64'd0);
    chk("rst_out_rd",     64'(out_rd),     64'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].ctrl, vecs[i].rs1, vecs[i].rs2, vecs[i].rd);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("vec%0d_result", i), out_result, vecs[i].exp);
      chk($sformatf("vec%0d_rd", i), 64'(out_rd), 64'(vecs[i].rd));
      tick();
      chk($sformatf("vec%0d_drained", i), 64'(out_valid), 64'd0);
    end

    // Backpressure: three back-to-back pushes with writeback stalled.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(3'b100, 64'd1, 64'd1, 5'd1);
    tick();
    chk("bp_ready_after1", 64'(in_ready), 64'd1);
    drive(3'b100, 64'd2, 64'd1, 5'd2);
    tick();
    chk("bp_ready_after2", 64'(in_ready), 64'd0);
    chk("bp_head_rd", 64'(out_rd), 64'd1);
    drive(3'b100, 64'd3, 64'd1, 5'd3);
    tick();
    chk("bp_third_held", 64'(in_ready), 64'd0);
    chk("bp_head_still1", 64'(out_rd), 64'd1);
    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 12 && got < 3; c++) begin
      if (out_valid && out_ready) begin
        tags[got] = out_rd;
        got++;
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) in_valid = 1'b0;
      if (c == 0) chk("full_no_push_on_pop", 64'(in_ready), 64'd1);
    end
    chk("bp_pop_count", 64'(got), 64'd3);
    chk("bp_tag0", 64'(tags[0]), 64'd1);
    chk("bp_tag1", 64'(tags[1]), 64'd2);
    chk("bp_tag2", 64'(tags[2]), 64'd3);
    tick();
    chk("bp_empty", 64'(out_valid), 64'd0);
    chk("bp_hold_rd", 64'(out_rd), 64'd3);
    chk("bp_hold_result", out_result, 64'd3);

    // Flush with two entries buffered and a push offered in the same cycle.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(3'b100, 64'd4, 64'd1, 5'd4);
    tick();
    drive(3'b100, 64'd5, 64'd1, 5'd5);
    tick();
    chk("fl_full", 64'(out_valid), 64'd1);
    drive(3'b100, 64'd6, 64'd1, 5'd6);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    chk("fl_in_ready", 64'(in_ready), 64'd1);
    tick();
    chk("fl_nothing_kept", 64'(out_valid), 64'd0);

    // Asynchronous reset in the middle of a burst.
    in_valid = 1'b1;
    drive(3'b100, 64'd7, 64'd1, 5'd7);
    tick();
    drive(3'b100, 64'd8, 64'd1, 5'd8);
    tick();
    chk("ar_pre_result", out_result, 64'd7);
    #2 rst = 1'b1;
    #1;
    chk("ar_out_valid",  64'(out_valid), 64'd0);
    chk("ar_in_ready",   64'(in_ready),  64'd1);
    chk("ar_out_result", out_result,     64'd0);
    chk("ar_out_rd",     64'(out_rd),    64'd0);
    in_valid = 1'b0;
    #1 rst = 1'b0;
    tick();
    chk("ar_still_empty", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    drive(3'b000, 64'd9, 64'd1, 5'd9);
    tick();
    in_valid = 1'b0;
    chk("ar_resume_rd", 64'(out_rd), 64'd9);
    chk("ar_resume_result", out_result, 64'd9);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
